// File: rtl/div_pkg.sv
// div_pkg: shared types and helpers for the iterative integer divider.
//   div_state_e  : FSM state encoding (IDLE, DIV, DONE)
//   SC_*         : special-case codes resolved when a request is accepted
//   neg_n        : two's-complement negate, result masked to n bits
//   sext_half    : sign-extend the low xlen/2 bits of a value to xlen bits
// Helpers work on a DIV_MAXW-bit container; callers size-cast in and out,
// which bounds the supported XLEN to DIV_MAXW-1.
package div_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_DONE = 2'd2
   } div_state_e;

   localparam logic [1:0] SC_NONE = 2'd0;  // normal iterative division
   localparam logic [1:0] SC_DIVZ = 2'd1;  // divisor == 0
   localparam logic [1:0] SC_OVF  = 2'd2;  // signed MIN / -1
   localparam logic [1:0] SC_ZERO = 2'd3;  // dividend == 0

   localparam int DIV_MAXW = 128;

   function automatic logic [DIV_MAXW-1:0] neg_n(input logic [DIV_MAXW-1:0] x,
                                                 input int n);
      logic [DIV_MAXW-1:0] mask;
      mask = (DIV_MAXW'(1) << n) - DIV_MAXW'(1);
      return (~x + DIV_MAXW'(1)) & mask;
   endfunction

   function automatic logic [DIV_MAXW-1:0] sext_half(input logic [DIV_MAXW-1:0] x,
                                                     input int xlen);
      logic [DIV_MAXW-1:0] r;
      r = x;
      for (int i = 0; i < DIV_MAXW; i++) begin
         if (i >= xlen)
            r[i] = 1'b0;
         else if (i >= xlen / 2)
            r[i] = x[xlen/2-1];
      end
      return r;
   endfunction

endpackage

// File: rtl/div_lzc.sv
// div_lzc: combinational leading-zero count.
//   data_i  [WIDTH]            value to scan
//   count_o [clog2(WIDTH+1)]   number of leading zeros (WIDTH when data_i == 0)
module div_lzc #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0]         data_i,
   output logic [$clog2(WIDTH+1)-1:0] count_o
);

   localparam int CW = $clog2(WIDTH + 1);

   // Scan upward; the highest set bit is the last one to write the count.
   always_comb begin
      count_o = CW'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (data_i[i])
            count_o = CW'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/iter_divider.sv
// iter_divider: multi-cycle restoring radix-2 divider (DIV/DIVU/REM/REMU + W forms).
//   clk, rst                 clock, synchronous active-high reset
//   flush                    abort any operation, back to IDLE next edge
//   in_valid/in_ready        request handshake; in_divw, in_signed, in_dividend,
//                            in_divisor, in_tag are the request payload
//   out_valid/out_ready      result handshake; out_quot, out_rem, out_tag payload
//   dbg_state_o              current FSM state (div_state_e encoding)
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. in_ready is high only in IDLE; out_valid is high only in DONE and the
// payload holds steady until out_ready. flush suppresses any accept that cycle.
// W forms run on the low XLEN/2 bits zero-padded to XLEN, so the same datapath
// serves both widths; the leading-zero count of the padded magnitude directly
// gives the iteration count K = XLEN - lzc = N - L.
import div_pkg::*;

module iter_divider #(
   parameter int XLEN  = 64,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_divw,
   input  logic             in_signed,
   input  logic [XLEN-1:0]  in_dividend,
   input  logic [XLEN-1:0]  in_divisor,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_quot,
   output logic [XLEN-1:0]  out_rem,
   output logic [TAG_W-1:0] out_tag,
   output logic [1:0]       dbg_state_o
);

   localparam int H  = XLEN / 2;
   localparam int CW = $clog2(XLEN + 1);

   div_state_e       state_q, state_d;
   logic [XLEN-1:0]  a_q, a_d;        // pre-shifted dividend magnitude
   logic [XLEN-1:0]  b_q, b_d;        // divisor magnitude
   logic [XLEN-1:0]  r_q, r_d;        // partial remainder
   logic [XLEN-1:0]  quot_q, quot_d;  // quotient shift register
   logic [CW-1:0]    cnt_q, cnt_d;    // iterations left
   logic             divw_q, divw_d;
   logic             negq_q, negq_d;
   logic             negr_q, negr_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [XLEN-1:0]  out_quot_q, out_quot_d;
   logic [XLEN-1:0]  out_rem_q, out_rem_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d;

   // Negate to the active width, then sign-extend W results from bit N-1.
   function automatic logic [XLEN-1:0] fix_res(input logic [XLEN-1:0] v,
                                                input logic neg, input logic divw);
      logic [XLEN-1:0] t;
      t = neg ? XLEN'(neg_n(DIV_MAXW'(v), divw ? H : XLEN)) : v;
      return divw ? XLEN'(sext_half(DIV_MAXW'(t), XLEN)) : t;
   endfunction

   // Request decode (only meaningful in IDLE).
   logic [XLEN-1:0] a_n, b_n, a_mag, b_mag, min_n, ones_n;
   logic            sa, sb, accept;
   logic [1:0]      sc;
   logic [CW-1:0]   lz;

   assign a_n    = in_divw ? {{H{1'b0}}, in_dividend[H-1:0]} : in_dividend;
   assign b_n    = in_divw ? {{H{1'b0}}, in_divisor[H-1:0]}  : in_divisor;
   assign sa     = in_signed & (in_divw ? in_dividend[H-1] : in_dividend[XLEN-1]);
   assign sb     = in_signed & (in_divw ? in_divisor[H-1]  : in_divisor[XLEN-1]);
   assign a_mag  = sa ? XLEN'(neg_n(DIV_MAXW'(a_n), in_divw ? H : XLEN)) : a_n;
   assign b_mag  = sb ? XLEN'(neg_n(DIV_MAXW'(b_n), in_divw ? H : XLEN)) : b_n;
   assign min_n  = in_divw ? (XLEN'(1) << (H - 1)) : (XLEN'(1) << (XLEN - 1));
   assign ones_n = in_divw ? {{H{1'b0}}, {H{1'b1}}} : {XLEN{1'b1}};
   assign accept = in_valid & in_ready & ~flush;

   // Divide-by-zero wins over the dividend==0 shortcut (0/0 gives all-ones quotient).
   always_comb begin
      if (b_n == '0)
         sc = SC_DIVZ;
      else if (in_signed && (a_n == min_n) && (b_n == ones_n))
         sc = SC_OVF;
      else if (a_n == '0)
         sc = SC_ZERO;
      else
         sc = SC_NONE;
   end

   div_lzc #(.WIDTH(XLEN)) u_lzc (
      .data_i  (a_mag),
      .count_o (lz)
   );

   // One restoring step: shift in next dividend bit, trial subtract divisor.
   logic [XLEN:0]   r_sh;
   logic [XLEN+1:0] diff;
   logic            ge;
   logic [XLEN-1:0] r_nx, q_nx;

   assign r_sh = {r_q, a_q[XLEN-1]};
   assign diff = {1'b0, r_sh} - {2'b00, b_q};
   assign ge   = ~diff[XLEN+1];
   assign r_nx = ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
   assign q_nx = {quot_q[XLEN-2:0], ge};

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      r_d        = r_q;
      quot_d     = quot_q;
      cnt_d      = cnt_q;
      divw_d     = divw_q;
      negq_d     = negq_q;
      negr_d     = negr_q;
      tag_d      = tag_q;
      out_quot_d = out_quot_q;
      out_rem_d  = out_rem_q;
      out_tag_d  = out_tag_q;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  divw_d    = in_divw;
                  negq_d    = sa ^ sb;
                  negr_d    = sa;
                  tag_d     = in_tag;
                  out_tag_d = in_tag;
                  state_d   = S_DONE;
                  case (sc)
                     SC_DIVZ: begin
                        out_quot_d = {XLEN{1'b1}};
                        out_rem_d  = fix_res(a_n, 1'b0, in_divw);
                     end
                     SC_OVF: begin
                        out_quot_d = fix_res(min_n, 1'b0, in_divw);
                        out_rem_d  = '0;
                     end
                     SC_ZERO: begin
                        out_quot_d = '0;
                        out_rem_d  = '0;
                     end
                     default: begin
                        a_d     = a_mag << lz;
                        b_d     = b_mag;
                        r_d     = '0;
                        quot_d  = '0;
                        cnt_d   = CW'(XLEN) - lz;
                        state_d = S_DIV;
                     end
                  endcase
               end
            end
            S_DIV: begin
               r_d    = r_nx;
               quot_d = q_nx;
               a_d    = a_q << 1;
               cnt_d  = cnt_q - CW'(1);
               // Final step also forms the signed result so out_valid follows at once.
               if (cnt_q == CW'(1)) begin
                  out_quot_d = fix_res(q_nx, negq_q, divw_q);
                  out_rem_d  = fix_res(r_nx, negr_q, divw_q);
                  out_tag_d  = tag_q;
                  state_d    = S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready)
                  state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         r_q        <= '0;
         quot_q     <= '0;
         cnt_q      <= '0;
         divw_q     <= 1'b0;
         negq_q     <= 1'b0;
         negr_q     <= 1'b0;
         tag_q      <= '0;
         out_quot_q <= '0;
         out_rem_q  <= '0;
         out_tag_q  <= '0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         r_q        <= r_d;
         quot_q     <= quot_d;
         cnt_q      <= cnt_d;
         divw_q     <= divw_d;
         negq_q     <= negq_d;
         negr_q     <= negr_d;
         tag_q      <= tag_d;
         out_quot_q <= out_quot_d;
         out_rem_q  <= out_rem_d;
         out_tag_q  <= out_tag_d;
      end
   end

   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_DONE);
   assign out_quot    = out_quot_q;
   assign out_rem     = out_rem_q;
   assign out_tag     = out_tag_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider (XLEN=64, TAG_W=4): directed vector table plus
// hand-written backpressure, flush and mid-operation reset sequences.
module tb_iter_divider;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic        in_divw;
   logic        in_signed;
   logic [63:0] in_dividend;
   logic [63:0] in_divisor;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_quot;
   logic [63:0] out_rem;
   logic [3:0]  out_tag;
   logic [1:0]  dbg_state;

   int n_cmp = 0;
   int n_bad = 0;

   iter_divider #(.XLEN(64), .TAG_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_divw     (in_divw),
      .in_signed   (in_signed),
      .in_dividend (in_dividend),
      .in_divisor  (in_divisor),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_quot    (out_quot),
      .out_rem     (out_rem),
      .out_tag     (out_tag),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checks ----------------
   task automatic chk64(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic chk_int(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Called #1 after a rising edge with the DUT in IDLE. Returns the result and
   // the latency counted from the accepting edge (1 = out_valid right after it);
   // lat = -1 on timeout. Leaves the DUT back in IDLE.
   task automatic run_op(input logic divw, input logic sgn,
                         input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag,
                         output logic [63:0] q, output logic [63:0] r,
                         output logic [3:0] t, output int lat);
      in_divw     = divw;
      in_signed   = sgn;
      in_dividend = a;
      in_divisor  = b;
      in_tag      = tag;
      out_ready   = 1'b1;
      in_valid    = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat <= 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!out_valid) lat = -1;
      q = out_quot;
      r = out_rem;
      t = out_tag;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        divw;
      logic        sgn;
      logic [63:0] a;
      logic [63:0] b;
      logic [3:0]  tag;
      logic [63:0] eq;
      logic [63:0] er;
      int          lat;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   logic [63:0] gq, gr;
   logic [3:0]  gt;
   int          glat;
   int          seen;

   initial begin
      // {divw, signed, dividend, divisor, tag, exp quot, exp rem, exp latency}
      vecs[0]  = '{1'b0, 1'b0, 64'd100, 64'd7, 4'd5, 64'd14, 64'd2, 8};
      vecs[1]  = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 4'd1,
                   64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 4};
      vecs[2]  = '{1'b0, 1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 4'd2,
                   64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 4};
      vecs[3]  = '{1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 4'd3,
                   64'hFFFF_FFFF_8000_0000, 64'd0, 1};
      vecs[4]  = '{1'b0, 1'b0, 64'd5, 64'd0, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1};
      vecs[5]  = '{1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd0, 4'd6,
                   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1};
      vecs[6]  = '{1'b0, 1'b0, 64'd1, 64'd1, 4'd7, 64'd1, 64'd0, 2};
      vecs[7]  = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd8,
                   64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65};
      vecs[8]  = '{1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 4'd9,
                   64'h8000_0000_0000_0000, 64'd0, 1};
      vecs[9]  = '{1'b0, 1'b0, 64'd0, 64'd9, 4'd10, 64'd0, 64'd0, 1};
      vecs[10] = '{1'b1, 1'b1, 64'hDEAD_BEEF_FFFF_FFF9, 64'd2, 4'd11,
                   64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 4};
      vecs[11] = '{1'b1, 1'b0, 64'h0000_0000_8000_0000, 64'd1, 4'd12,
                   64'hFFFF_FFFF_8000_0000, 64'd0, 33};
      vecs[12] = '{1'b0, 1'b0, 64'd1000, 64'd10, 4'd13, 64'd100, 64'd0, 11};
      vecs[13] = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 4'd14,
                   64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 8};
      vecs[14] = '{1'b1, 1'b1, 64'd100, 64'h1234_5678_FFFF_FFF9, 4'd15,
                   64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 8};
      vecs[15] = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'd0,
                   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1};

      rst         = 1'b1;
      flush       = 1'b0;
      in_valid    = 1'b0;
      in_divw     = 1'b0;
      in_signed   = 1'b0;
      in_dividend = '0;
      in_divisor  = '0;
      in_tag      = '0;
      out_ready   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // ---- reset state ----
      chk64("reset out_valid", {63'd0, out_valid}, 64'd0);
      chk64("reset in_ready", {63'd0, in_ready}, 64'd1);
      chk64("reset out_quot", out_quot, 64'd0);
      chk64("reset out_rem", out_rem, 64'd0);
      chk64("reset out_tag", {60'd0, out_tag}, 64'd0);

      // ---- vector table ----
      for (int i = 0; i < NV; i++) begin
         run_op(vecs[i].divw, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].tag,
                gq, gr, gt, glat);
         chk_int($sformatf("vec%0d latency", i), glat, vecs[i].lat);
         chk64($sformatf("vec%0d quot", i), gq, vecs[i].eq);
         chk64($sformatf("vec%0d rem", i), gr, vecs[i].er);
         chk64($sformatf("vec%0d tag", i), {60'd0, gt}, {60'd0, vecs[i].tag});
      end

      // ---- backpressure: hold result for 10 cycles ----
      out_ready   = 1'b0;
      in_divw     = 1'b0;
      in_signed   = 1'b0;
      in_dividend = 64'd100;
      in_divisor  = 64'd7;
      in_tag      = 4'd9;
      in_valid    = 1'b1;
      @(posedge clk);
      #1;
      in_dividend = 64'd55;   // competing request that must not be taken
      in_divisor  = 64'd5;
      in_tag      = 4'd3;
      seen = 0;
      for (int i = 0; i < 20 && !out_valid; i++) begin
         @(posedge clk);
         #1;
      end
      chk64("bp out_valid", {63'd0, out_valid}, 64'd1);
      for (int i = 0; i < 10; i++) begin
         chk64($sformatf("bp hold%0d quot", i), out_quot, 64'd14);
         chk64($sformatf("bp hold%0d rem", i), out_rem, 64'd2);
         chk64($sformatf("bp hold%0d tag/valid/ready", i),
               {58'd0, out_tag, out_valid, in_ready}, {58'd0, 4'd9, 1'b1, 1'b0});
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk64("bp release out_valid", {63'd0, out_valid}, 64'd0);
      chk64("bp release in_ready", {63'd0, in_ready}, 64'd1);

      // ---- flush at iteration 20 of a full 64-bit op ----
      in_divw     = 1'b0;
      in_signed   = 1'b0;
      in_dividend = 64'hFFFF_FFFF_FFFF_FFFF;
      in_divisor  = 64'd3;
      in_tag      = 4'd6;
      in_valid    = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      chk64("flush pre in_ready", {63'd0, in_ready}, 64'd0);
      flush       = 1'b1;
      in_valid    = 1'b1;
      in_dividend = 64'd1;
      in_divisor  = 64'd1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      chk64("flush in_ready", {63'd0, in_ready}, 64'd1);
      chk64("flush out_valid", {63'd0, out_valid}, 64'd0);
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         if (out_valid) seen++;
         @(posedge clk);
         #1;
      end
      chk_int("flush no result", seen, 0);
      run_op(1'b0, 1'b0, 64'd1000, 64'd10, 4'd2, gq, gr, gt, glat);
      chk64("post-flush quot", gq, 64'd100);
      chk64("post-flush rem", gr, 64'd0);
      chk_int("post-flush latency", glat, 11);

      // ---- reset in the middle of an operation ----
      in_dividend = 64'd100;
      in_divisor  = 64'd7;
      in_tag      = 4'd4;
      in_valid    = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk64("midrst out_valid/in_ready", {62'd0, out_valid, in_ready}, 64'd1);
      chk64("midrst out_quot", out_quot, 64'd0);
      chk64("midrst out_rem", out_rem, 64'd0);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) seen++;
         @(posedge clk);
         #1;
      end
      chk_int("midrst no result", seen, 0);
      run_op(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 4'd1, gq, gr, gt, glat);
      chk64("post-rst quot", gq, 64'hFFFF_FFFF_FFFF_FFF2);
      chk64("post-rst rem", gr, 64'hFFFF_FFFF_FFFF_FFFE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
